// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the MIPS core run controller.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    HALTED,
    TIMEOUT
  } run_state_t;

  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_3000;
  localparam int unsigned DEF_RST_CYCLES  = 2;
  localparam int unsigned DEF_HALT_REPEAT = 3;
  localparam int unsigned DEF_MAX_CYCLES  = 10000;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset sequencing, PC self-loop
// halt detection, cycle timeout and run statistics.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
  parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [PC_W-1:0]  pc,
  input  logic             reg_we,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] wb_count,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int unsigned HW = (RST_CYCLES  < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam int unsigned SW = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);

  // RESET_PC is informational only; it is sanity-checked here and nowhere else.
  if ((RESET_PC[1:0] != 2'b00) || (RST_CYCLES < 1) || (HALT_REPEAT < 1) || (MAX_CYCLES < 2))
  begin : g_param_check
    $error("cpu_run_ctrl: illegal parameter combination");
  end

  run_state_t      state, state_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [SW-1:0]   same_cnt, same_nxt;
  logic            first, first_nxt;
  logic [PC_W-1:0] prev_pc, prev_nxt;
  logic [PC_W-1:0] halt_pc_nxt;
  logic            cpu_reset_nxt, running_nxt, done_nxt, timeout_nxt;
  logic            cyc_inc, ins_inc, wb_inc, halt_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      same_cnt  <= '0;
      first     <= 1'b1;
      prev_pc   <= '0;
      halt_pc   <= '0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      same_cnt  <= same_nxt;
      first     <= first_nxt;
      prev_pc   <= prev_nxt;
      halt_pc   <= halt_pc_nxt;
      cpu_reset <= cpu_reset_nxt;
      running   <= running_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_cnt;
    same_nxt      = same_cnt;
    first_nxt     = first;
    prev_nxt      = prev_pc;
    halt_pc_nxt   = halt_pc;
    cpu_reset_nxt = cpu_reset;
    done_nxt      = done;
    timeout_nxt   = timeout;
    cyc_inc       = 1'b0;
    ins_inc       = 1'b0;
    wb_inc        = 1'b0;
    halt_hit      = 1'b0;

    if (restart) begin
      state_nxt     = HOLD;
      hold_nxt      = '0;
      same_nxt      = '0;
      first_nxt     = 1'b1;
      halt_pc_nxt   = '0;
      cpu_reset_nxt = 1'b1;
      done_nxt      = 1'b0;
      timeout_nxt   = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          cpu_reset_nxt = 1'b1;
          hold_nxt      = hold_cnt + HW'(1);
          if (hold_cnt == HW'(RST_CYCLES - 1)) begin
            state_nxt     = RUN;
            cpu_reset_nxt = 1'b0;
          end
        end
        RUN: begin
          cyc_inc = 1'b1;
          wb_inc  = reg_we;
          if (first) begin
            ins_inc   = 1'b1;
            first_nxt = 1'b0;
            prev_nxt  = pc;
            same_nxt  = '0;
          end else if (pc != prev_pc) begin
            ins_inc  = 1'b1;
            prev_nxt = pc;
            same_nxt = '0;
          end else begin
            same_nxt = same_cnt + SW'(1);
            halt_hit = (same_nxt == SW'(HALT_REPEAT));
          end
          // Halt is tested first so a coincident timeout is never reported.
          if (halt_hit) begin
            state_nxt     = HALTED;
            halt_pc_nxt   = pc;
            done_nxt      = 1'b1;
            cpu_reset_nxt = 1'b1;
          end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            state_nxt     = TIMEOUT;
            timeout_nxt   = 1'b1;
            done_nxt      = 1'b1;
            cpu_reset_nxt = 1'b1;
          end
        end
        HALTED, TIMEOUT: begin
          cpu_reset_nxt = 1'b1;
        end
        default: begin
          state_nxt = HOLD;
        end
      endcase
    end

    running_nxt = (state_nxt == RUN);
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .inc   (cyc_inc),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .inc   (ins_inc),
    .q     (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .inc   (wb_inc),
    .q     (wb_count)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: two instances differing only in MAX_CYCLES.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic        restart;
  logic [31:0] pc;
  logic        reg_we;

  logic        a_cpu_reset, a_running, a_done, a_timeout;
  logic [31:0] a_cycle, a_instr, a_wb, a_halt_pc;
  logic        b_cpu_reset, b_running, b_done, b_timeout;
  logic [31:0] b_cycle, b_instr, b_wb, b_halt_pc;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(2), .HALT_REPEAT(3),
    .MAX_CYCLES(8), .RESET_PC(32'h0000_3000)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .pc(pc), .reg_we(reg_we),
    .cpu_reset(a_cpu_reset), .running(a_running), .done(a_done), .timeout(a_timeout),
    .cycle_count(a_cycle), .instr_count(a_instr), .wb_count(a_wb), .halt_pc(a_halt_pc)
  );

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(2), .HALT_REPEAT(3),
    .MAX_CYCLES(6), .RESET_PC(32'h0000_3000)
  ) dut6 (
    .clk(clk), .reset(reset), .restart(restart), .pc(pc), .reg_we(reg_we),
    .cpu_reset(b_cpu_reset), .running(b_running), .done(b_done), .timeout(b_timeout),
    .cycle_count(b_cycle), .instr_count(b_instr), .wb_count(b_wb), .halt_pc(b_halt_pc)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] halt_seq [6];

  initial begin
    halt_seq[0] = 32'h3000; halt_seq[1] = 32'h3004; halt_seq[2] = 32'h3008;
    halt_seq[3] = 32'h3008; halt_seq[4] = 32'h3008; halt_seq[5] = 32'h3008;

    reset = 1'b0; restart = 1'b0; pc = 32'h3000; reg_we = 1'b0;
    #1;
    check("rst_cpu_reset", a_cpu_reset, 1'b1);
    check("rst_running",   a_running,   1'b0);
    check("rst_done",      a_done,      1'b0);
    check("rst_cycle",     a_cycle,     32'd0);
    check("rst_halt_pc",   a_halt_pc,   32'd0);

    // Release at t=15, between edges; reg_we high through HOLD must not count.
    #14 reset = 1'b1; reg_we = 1'b1;
    step();
    check("hold1_cpu_reset", a_cpu_reset, 1'b1);
    check("hold1_running",   a_running,   1'b0);
    step();
    check("hold2_cpu_reset", a_cpu_reset, 1'b0);
    check("hold2_running",   a_running,   1'b1);
    check("hold2_wb",        a_wb,        32'd0);

    // Halt sequence with reg_we on the first four RUN edges.
    for (int i = 0; i < 6; i++) begin
      pc = halt_seq[i];
      reg_we = (i < 4);
      step();
      if (i == 4) begin
        check("pre_halt_done",  a_done,  1'b0);
        check("pre_halt_cycle", a_cycle, 32'd5);
      end
    end
    check("halt_done",      a_done,      1'b1);
    check("halt_timeout",   a_timeout,   1'b0);
    check("halt_pc",        a_halt_pc,   32'h3008);
    check("halt_instr",     a_instr,     32'd3);
    check("halt_cycle",     a_cycle,     32'd6);
    check("halt_cpu_reset", a_cpu_reset, 1'b1);
    check("halt_running",   a_running,   1'b0);
    check("halt_wb",        a_wb,        32'd4);
    check("coinc_done",     b_done,      1'b1);
    check("coinc_timeout",  b_timeout,   1'b0);
    check("coinc_halt_pc",  b_halt_pc,   32'h3008);

    for (int i = 0; i < 3; i++) begin
      reg_we = (i % 2 == 0);
      pc = 32'h5000 + 32'(i);
      step();
    end
    check("halted_wb_hold",    a_wb,      32'd4);
    check("halted_cycle_hold", a_cycle,   32'd6);
    check("halted_pc_hold",    a_halt_pc, 32'h3008);

    // Restart from HALTED.
    reg_we = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs_done",      a_done,      1'b0);
    check("rs_cycle",     a_cycle,     32'd0);
    check("rs_instr",     a_instr,     32'd0);
    check("rs_wb",        a_wb,        32'd0);
    check("rs_halt_pc",   a_halt_pc,   32'd0);
    check("rs_cpu_reset", a_cpu_reset, 1'b1);
    check("rs_running",   a_running,   1'b0);
    step();
    check("rs_hold_cpu_reset", a_cpu_reset, 1'b1);
    step();
    check("rs_run_cpu_reset", a_cpu_reset, 1'b0);
    check("rs_run_running",   a_running,   1'b1);

    // Ever-advancing PC: MAX_CYCLES=8 instance times out on the 8th RUN edge.
    for (int i = 0; i < 8; i++) begin
      pc = 32'h3000 + 32'(4 * i);
      step();
      if (i == 6) check("pre_to_done", a_done, 1'b0);
    end
    check("to_timeout",   a_timeout,   1'b1);
    check("to_done",      a_done,      1'b1);
    check("to_cycle",     a_cycle,     32'd8);
    check("to_instr",     a_instr,     32'd8);
    check("to_halt_pc",   a_halt_pc,   32'd0);
    check("to_cpu_reset", a_cpu_reset, 1'b1);
    check("to6_timeout",  b_timeout,   1'b1);
    check("to6_cycle",    b_cycle,     32'd6);
    check("to6_instr",    b_instr,     32'd6);

    // Asynchronous reset asserted mid-RUN, between edges.
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    step();
    pc = 32'h4000; step();
    pc = 32'h4004; step();
    check("mid_cycle", a_cycle, 32'd2);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_cpu_reset", a_cpu_reset, 1'b1);
    check("arst_running",   a_running,   1'b0);
    check("arst_cycle",     a_cycle,     32'd0);
    check("arst_instr",     a_instr,     32'd0);
    #2 reset = 1'b1;
    step();
    check("arst_hold_cpu_reset", a_cpu_reset, 1'b1);
    step();
    check("arst_run_cpu_reset", a_cpu_reset, 1'b0);
    check("arst_run_running",   a_running,   1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run controller for the single-cycle MIPS core, sitting between the board or bench reset and the `mips` instance.
- Sequences the core's reset over a parametrised number of cycles.
- Monitors the fetched PC and detects the end of a program (PC self-loop).
- Enforces a cycle-count timeout.
- Keeps cycle, instruction and register-writeback counters for self-checking simulation and on-board status.

Parameters:
PC_W, 32, PC width
CNT_W, 32, width of all counters
RST_CYCLES, 2, cycles cpu_reset is held after external reset release or restart (>=1)
HALT_REPEAT, 3, consecutive unchanged-PC cycles that declare halt (>=1)
MAX_CYCLES, 10000, RUN cycles before timeout (>=2)
RESET_PC, 32'h0000_3000, PC the core fetches out of reset (reporting only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low controller reset
restart  in  1  synchronous pulse; restart the program from reset
pc  in  PC_W  current PC from the core
reg_we  in  1  core register-file write enable
cpu_reset  out  1  active-high synchronous reset to the core
running  out  1  state==RUN
done  out  1  program finished (halt or timeout)
timeout  out  1  finished by timeout
cycle_count  out  CNT_W  RUN cycles elapsed
instr_count  out  CNT_W  distinct-PC instructions executed
wb_count  out  CNT_W  RUN cycles with reg_we=1
halt_pc  out  PC_W  PC at halt

Behaviour:
Reset (reset=0, asynchronous):
- State=HOLD, hold_cnt=0, same_cnt=0, first=1.
- cpu_reset=1; running, done and timeout =0; all counters =0; halt_pc=0.
- The outputs take these values immediately, without waiting for a clock edge.

States: HOLD, RUN, HALTED, TIMEOUT. All outputs are registered.

HOLD:
- cpu_reset=1.
- hold_cnt increments each edge.
- When hold_cnt==RST_CYCLES-1, go to RUN and load cpu_reset=0 on that same edge.
- Result: cpu_reset is high for exactly RST_CYCLES edges after reset release.

RUN (each edge):
- cycle_count+1, saturating at all-ones.
- reg_we=1: wb_count+1. reg_we is ignored in all other states.
- first=1: instr_count+1, first<=0, prev_pc<=pc, same_cnt=0.
- Else pc!=prev_pc: instr_count+1, same_cnt=0, prev_pc<=pc.
- Else (pc==prev_pc): same_cnt+1.
- Halt: if the next same_cnt would be ==HALT_REPEAT, go to HALTED with halt_pc<=pc, done<=1, cpu_reset<=1.
- Timeout: else if cycle_count==MAX_CYCLES-1, go to TIMEOUT with timeout<=1, done<=1, cpu_reset<=1.
- Halt and timeout on the same edge: halt wins and timeout stays 0.
- RESET_PC is not used by the RUN logic.

HALTED / TIMEOUT:
- cpu_reset=1, which freezes the core.
- Counters, halt_pc and flags hold their values.

restart=1 (any state, synchronous):
- Next state HOLD.
- hold_cnt, same_cnt and all counters cleared; first=1.
- done, timeout and halt_pc cleared; cpu_reset<=1.
- restart has priority over every RUN transition.

Width rules:
- Counters are CNT_W, unsigned and saturating.
- hold_cnt and same_cnt are sized with $clog2 of their limit (+1).
- PC compare is the full PC_W bits.

Decomposition:
- Package cpu_run_pkg:
  - run_state_t enum {HOLD, RUN, HALTED, TIMEOUT}.
  - Default constants DEF_RESET_PC=32'h3000, DEF_RST_CYCLES=2, DEF_HALT_REPEAT=3, DEF_MAX_CYCLES=10000.
- Sub-module sat_counter:
  - Parameter W; inputs clk, reset, clr, inc; output q.
  - Asynchronous active-low reset; saturating increment.
  - Instantiated three times (cycle, instr, wb).

Test Plan:
1. Reset release at t=15ns, RST_CYCLES=2 -> cpu_reset high for exactly 2 rising edges after release, then 0; running=1 from the same edge.
2. PC sequence 0x3000, 0x3004, 0x3008, 0x3008, 0x3008, 0x3008 with HALT_REPEAT=3 -> after 6th RUN edge: done=1, timeout=0, halt_pc=0x3008, instr_count=3, cycle_count=6, cpu_reset=1.
3. PC incrementing by 4 forever, MAX_CYCLES=8 -> after 8th RUN edge: timeout=1, done=1, cycle_count=8, instr_count=8, halt_pc=0.
4. Sequence of test 2 with MAX_CYCLES=6 -> halt and timeout coincide; done=1, timeout=0, halt_pc=0x3008.
5. reg_we=1 during both HOLD cycles and on 4 RUN cycles, then halt -> wb_count=4; reg_we toggling in HALTED leaves wb_count=4.
6. Reset driven low mid-RUN between clock edges -> cpu_reset=1 and all counters 0 immediately. Later, restart pulse in HALTED -> HOLD, counters 0, done=0, cpu_reset high 2 edges, then RUN.
